mor1kx_irq_sched: RTL and testbench

Interrupt scheduler between the programmable interrupt controller's status vector and the CPU exception unit. It selects one pending line from the PIC status register and presents it to the CPU as a single registered request with a 5-bit line ID. It holds that request until the CPU acknowledges it, then waits for end-of-interrupt and an optional hold-off interval before arbitrating again.

---
 rtl/mor1kx_irq_sched.sv | 82 ++++++++
 tb/tb_mor1kx_irq_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_irq_sched.sv
// mor1kx_irq_sched: picks one pending PIC line and hands it to the CPU as a held request.
// Optional build macro MOR1KX_IRQ_SCHED_ROUND_ROBIN_EN selects round-robin instead of lowest-index priority.
module mor1kx_irq_sched #(
    parameter int OPTION_IRQ_HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] picsr_i,
    input  logic        iee_i,
    input  logic        ack_i,
    input  logic        eoi_i,
    output logic        irq_o,
    output logic [4:0]  irq_id_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE, HOLDOFF} state_t;
    localparam logic [7:0] HOLDOFF_LOAD = (OPTION_IRQ_HOLDOFF > 0) ? 8'(OPTION_IRQ_HOLDOFF - 1) : 8'd0;
    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_id;
    logic [7:0] r_cnt;
    logic [4:0] w_sel;
`ifdef MOR1KX_IRQ_SCHED_ROUND_ROBIN_EN
    logic [4:0] r_rr_ptr;
    logic [4:0] w_idx;
    // round-robin search from r_rr_ptr upward; iterating backwards lets the nearest hit win
    always_comb begin
        w_sel = 5'd0;
        w_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            w_idx = 5'(i) + r_rr_ptr;
            if (picsr_i[w_idx]) w_sel = w_idx;
        end
    end
    // pointer moves past the line the CPU actually took; withdrawal leaves it alone
    always_ff @(posedge clk) begin
        if (rst) r_rr_ptr <= 5'd0;
        else if (r_state == REQ && ack_i) r_rr_ptr <= r_id + 5'd1;
    end
`else
    // fixed priority: lowest set index wins
    always_comb begin
        w_sel = 5'd0;
        for (int i = 31; i >= 0; i--)
            if (picsr_i[i]) w_sel = 5'(i);
    end
`endif
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next state; ack beats withdrawal in REQ, eoi only matters in SERVICE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|picsr_i && iee_i) w_next = REQ;
            REQ:     if (ack_i) w_next = SERVICE;
                     else if (!picsr_i[r_id]) w_next = IDLE;
            SERVICE: if (eoi_i) w_next = (OPTION_IRQ_HOLDOFF == 0) ? IDLE : HOLDOFF;
            HOLDOFF: if (r_cnt == 8'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // latched line id and holdoff counter; the counter saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id  <= 5'd0;
            r_cnt <= 8'd0;
        end else begin
            if (r_state == IDLE && w_next == REQ) r_id <= w_sel;
            if (r_state == SERVICE && eoi_i) r_cnt <= HOLDOFF_LOAD;
            else if (r_state == HOLDOFF && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
    end
    // outputs; the request is masked by iee_i without leaving REQ
    always_comb begin
        irq_o    = (r_state == REQ) && iee_i;
        irq_id_o = r_id;
        busy_o   = (r_state != IDLE);
    end
endmodule

// File: tb/tb_mor1kx_irq_sched.sv
// tb_mor1kx_irq_sched: directed stimulus with a behavioural model checked every cycle plus literal checks.
module tb_mor1kx_irq_sched;
    localparam int H = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] picsr = 32'd0;
    logic        iee = 1'b1;
    logic        ack = 1'b0;
    logic        eoi = 1'b0;
    logic        irq;
    logic [4:0]  id;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    mor1kx_irq_sched #(.OPTION_IRQ_HOLDOFF(H)) dut (
        .clk(clk), .rst(rst), .picsr_i(picsr), .iee_i(iee), .ack_i(ack), .eoi_i(eoi),
        .irq_o(irq), .irq_id_o(id), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
        end
    endtask

    // model: a request is either waiting for ack, being serviced, or the block is quiet for some cycles
    bit m_on, m_pend, m_serv;
    int m_quiet, m_id, m_rr;

    function automatic int pick(input logic [31:0] v, input int start);
        for (int k = 0; k < 32; k++)
            if (v[(start + k) % 32]) return (start + k) % 32;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1; m_pend = 0; m_serv = 0; m_quiet = 0; m_id = 0; m_rr = 0;
        end else if (m_pend) begin
            if (ack) begin
                m_pend = 0; m_serv = 1; m_rr = (m_id + 1) % 32;
            end else if (!picsr[m_id]) m_pend = 0;
        end else if (m_serv) begin
            if (eoi) begin
                m_serv = 0; m_quiet = H;
            end
        end else if (m_quiet > 0) m_quiet--;
        else if (picsr != 0 && iee) begin
            m_pend = 1;
`ifdef MOR1KX_IRQ_SCHED_ROUND_ROBIN_EN
            m_id = pick(picsr, m_rr);
`else
            m_id = pick(picsr, 0);
`endif
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model_irq", {31'd0, irq}, {31'd0, m_pend && iee});
            chk("model_id", {27'd0, id}, 32'(m_id));
            chk("model_busy", {31'd0, busy}, {31'd0, m_pend || m_serv || m_quiet > 0});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // take the current request, retire it, sit out the holdoff, then present the next vector
    task automatic serve(input int e, input logic [31:0] nxt);
        chk("serve_irq", {31'd0, irq}, 32'd1);
        chk("serve_id", {27'd0, id}, 32'(e));
        ack = 1; tick(); ack = 0;
        eoi = 1; tick(); eoi = 0;
        tick(4);
        chk("serve_idle", {31'd0, busy}, 32'd0);
        picsr = nxt;
        tick();
    endtask

    initial begin
        tick(2);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_id", {27'd0, id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 0;
        picsr = 32'h0000_0010;
        tick();
        chk("hs_irq", {31'd0, irq}, 32'd1);
        chk("hs_id", {27'd0, id}, 32'd4);
        ack = 1; tick(); ack = 0;
        chk("hs_ack_irq", {31'd0, irq}, 32'd0);
        chk("hs_ack_busy", {31'd0, busy}, 32'd1);
        picsr = 32'd0;
        eoi = 1; tick(); eoi = 0;
        chk("hs_hold1", {31'd0, busy}, 32'd1);
        tick(3);
        chk("hs_hold4", {31'd0, busy}, 32'd1);
        tick();
        chk("hs_free5", {31'd0, busy}, 32'd0);
`ifdef MOR1KX_IRQ_SCHED_ROUND_ROBIN_EN
        picsr = 32'h8000_0003;
        tick();
        serve(0, 32'h8000_0003);
        serve(1, 32'h8000_0003);
        serve(31, 32'h8000_0003);
        serve(0, 32'd0);
`else
        picsr = 32'h8000_0006;
        tick();
        serve(1, 32'h8000_0006);
        serve(1, 32'h8000_0006);
        serve(1, 32'h8000_0004);
        serve(2, 32'd0);
`endif
        picsr = 32'h0000_0020;
        tick();
        chk("wd_id", {27'd0, id}, 32'd5);
        picsr = 32'd0;
        tick();
        chk("wd_irq", {31'd0, irq}, 32'd0);
        chk("wd_busy", {31'd0, busy}, 32'd0);
        picsr = 32'h0000_0020;
        tick();
        picsr = 32'd0; ack = 1; eoi = 1;
        tick();
        ack = 0; eoi = 0;
        chk("race_busy", {31'd0, busy}, 32'd1);
        chk("race_irq", {31'd0, irq}, 32'd0);
        chk("race_id", {27'd0, id}, 32'd5);
        tick();
        chk("race_svc", {31'd0, busy}, 32'd1);
        eoi = 1; tick(); eoi = 0;
        tick();
        rst = 1; tick(); rst = 0;
        chk("rho_busy", {31'd0, busy}, 32'd0);
        chk("rho_id", {27'd0, id}, 32'd0);
        eoi = 1; tick(); eoi = 0;
        chk("rho_eoi", {31'd0, busy}, 32'd0);
        picsr = 32'h0000_0004;
        tick();
        ack = 1; tick(); ack = 0;
        chk("rsv_busy", {31'd0, busy}, 32'd1);
        rst = 1; picsr = 32'd0; tick(); rst = 0;
        chk("rsv_busy0", {31'd0, busy}, 32'd0);
        chk("rsv_irq0", {31'd0, irq}, 32'd0);
        chk("rsv_id0", {27'd0, id}, 32'd0);
        eoi = 1; tick(); eoi = 0;
        chk("rsv_eoi", {31'd0, busy}, 32'd0);
        picsr = 32'h0000_0100;
        tick();
        chk("gate_id", {27'd0, id}, 32'd8);
        iee = 0; picsr = 32'h0000_0101;
        repeat (3) begin
            tick();
            chk("gate_irq0", {31'd0, irq}, 32'd0);
            chk("gate_id8", {27'd0, id}, 32'd8);
        end
        iee = 1; tick();
        chk("gate_irq1", {31'd0, irq}, 32'd1);
        chk("gate_keep", {27'd0, id}, 32'd8);
        ack = 1; tick(); ack = 0;
        eoi = 1; tick(); eoi = 0;
        tick(4);
        iee = 0; picsr = 32'h0000_0001;
        tick(3);
        chk("iee0_busy", {31'd0, busy}, 32'd0);
        iee = 1; tick();
        chk("iee1_irq", {31'd0, irq}, 32'd1);
        chk("iee1_id", {27'd0, id}, 32'd0);
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
